// File: rtl/sa_ws_controller.sv
// Weight-stationary systolic array sequencer: weight tile fetch/burst load, activation streaming, drain and result tagging.
// Optional build macro SA_CTRL_SKEW_EN adds per-row activation skew (row r delayed r cycles) in front of the array.
module sa_ws_controller #(
  parameter int unsigned WORDWIDTH  = 8,
  parameter int unsigned ARRWIDTH   = 4,
  parameter int unsigned ARRHEIGHT  = 4,
  parameter int unsigned VEC_CNT_W  = 8,
  parameter int unsigned PS_LATENCY = ARRHEIGHT + ARRWIDTH - 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [VEC_CNT_W-1:0]              num_vectors,
  output logic                              busy,
  output logic                              done,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [WORDWIDTH*ARRWIDTH-1:0]     w_data,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [WORDWIDTH*ARRHEIGHT-1:0]    a_data,
  output logic                              sa_mode,
  output logic [WORDWIDTH*ARRWIDTH-1:0]     sa_w_in_vec,
  output logic [WORDWIDTH*ARRHEIGHT-1:0]    sa_a_in_vec,
  input  logic [WORDWIDTH*4*ARRWIDTH-1:0]   sa_ps_out_vec,
  output logic                              out_valid,
  output logic [WORDWIDTH*4*ARRWIDTH-1:0]   out_data,
  output logic [VEC_CNT_W-1:0]              out_index
);

  localparam int unsigned W_VEC_W = WORDWIDTH * ARRWIDTH;
  localparam int unsigned A_VEC_W = WORDWIDTH * ARRHEIGHT;
  localparam int unsigned ROW_W   = (ARRHEIGHT > 1) ? $clog2(ARRHEIGHT) : 1;
`ifdef SA_CTRL_SKEW_EN
  localparam int unsigned SKEW    = ARRHEIGHT - 1;
`else
  localparam int unsigned SKEW    = 0;
`endif
  // Valid/index pipeline spans the array latency, the result register slot and any row skew.
  localparam int unsigned DL_LEN  = PS_LATENCY + 2 + SKEW;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_W, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t               state, state_nx;
  logic [ROW_W-1:0]     row_cnt, row_cnt_nx;
  logic [VEC_CNT_W-1:0] acc_cnt, acc_cnt_nx;
  logic [VEC_CNT_W-1:0] num_q, num_q_nx;
  logic [W_VEC_W-1:0]   wbuf [ARRHEIGHT];
  logic [DL_LEN-1:0]    vld_dl;
  logic [VEC_CNT_W-1:0] idx_dl [DL_LEN];
  logic                 w_hs, a_hs;

  logic                 busy_d, done_d, w_ready_d, a_ready_d, sa_mode_d;
  logic [W_VEC_W-1:0]   sa_w_in_vec_d;
  logic [A_VEC_W-1:0]   a_stage_d;

  assign w_hs = w_valid & w_ready;
  assign a_hs = a_valid & a_ready;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      acc_cnt <= '0;
      num_q   <= '0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_cnt_nx;
      acc_cnt <= acc_cnt_nx;
      num_q   <= num_q_nx;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nx   = state;
    row_cnt_nx = row_cnt;
    acc_cnt_nx = acc_cnt;
    num_q_nx   = num_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_FETCH_W;
          num_q_nx   = num_vectors;
          row_cnt_nx = '0;
          acc_cnt_nx = '0;
        end
      end
      S_FETCH_W: begin
        if (w_hs) begin
          if (row_cnt == ROW_W'(ARRHEIGHT - 1)) begin
            row_cnt_nx = '0;
            state_nx   = S_LOAD_W;
          end else begin
            row_cnt_nx = row_cnt + ROW_W'(1);
          end
        end
      end
      S_LOAD_W: begin
        if (row_cnt == ROW_W'(ARRHEIGHT - 1)) begin
          row_cnt_nx = '0;
          state_nx   = (num_q == '0) ? S_DONE : S_STREAM;
        end else begin
          row_cnt_nx = row_cnt + ROW_W'(1);
        end
      end
      S_STREAM: begin
        // acc_cnt < num_q here, so the increment cannot wrap even at the maximum count
        if (a_hs) begin
          acc_cnt_nx = acc_cnt + VEC_CNT_W'(1);
          if (acc_cnt_nx == num_q) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_dl == '0) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state
  always_comb begin
    busy_d        = (state_nx != S_IDLE);
    done_d        = (state_nx == S_DONE);
    w_ready_d     = (state_nx == S_FETCH_W);
    a_ready_d     = (state_nx == S_STREAM) && (acc_cnt_nx < num_q_nx);
    sa_mode_d     = (state_nx != S_LOAD_W);
    sa_w_in_vec_d = '0;
    if (state_nx == S_LOAD_W) begin
      // forward the row being written this cycle (single-row tiles only)
      sa_w_in_vec_d = (w_hs && (row_cnt == row_cnt_nx)) ? w_data : wbuf[row_cnt_nx];
    end
    a_stage_d     = a_hs ? a_data : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      w_ready     <= 1'b0;
      a_ready     <= 1'b0;
      sa_mode     <= 1'b1;
      sa_w_in_vec <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      w_ready     <= w_ready_d;
      a_ready     <= a_ready_d;
      sa_mode     <= sa_mode_d;
      sa_w_in_vec <= sa_w_in_vec_d;
    end
  end

  // Weight tile buffer
  always_ff @(posedge clk) begin
    if (w_hs) wbuf[row_cnt] <= w_data;
  end

  // Activation rows into the array, optionally skewed into a diagonal wavefront
  for (genvar r = 0; r < ARRHEIGHT; r++) begin : g_row
    logic [WORDWIDTH-1:0] row_q;
`ifdef SA_CTRL_SKEW_EN
    if (r == 0) begin : g_direct
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) row_q <= '0;
        else          row_q <= a_stage_d[r*WORDWIDTH +: WORDWIDTH];
      end
    end else begin : g_skew
      logic [WORDWIDTH-1:0] sk [r];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
          row_q <= '0;
        end else begin
          sk[0] <= a_stage_d[r*WORDWIDTH +: WORDWIDTH];
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
          row_q <= sk[r-1];
        end
      end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) row_q <= '0;
      else          row_q <= a_stage_d[r*WORDWIDTH +: WORDWIDTH];
    end
`endif
    assign sa_a_in_vec[r*WORDWIDTH +: WORDWIDTH] = row_q;
  end

  // Valid/index delay line and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_dl    <= '0;
      for (int i = 0; i < DL_LEN; i++) idx_dl[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      vld_dl    <= {vld_dl[DL_LEN-2:0], a_hs};
      idx_dl[0] <= acc_cnt;
      for (int i = 1; i < DL_LEN; i++) idx_dl[i] <= idx_dl[i-1];
      out_valid <= vld_dl[DL_LEN-1];
      if (vld_dl[DL_LEN-1]) begin
        out_data  <= sa_ps_out_vec;
        out_index <= idx_dl[DL_LEN-1];
      end
    end
  end

endmodule

// File: tb/tb_sa_ws_controller.sv
// Directed bench for sa_ws_controller (default build): per-cycle vector table plus multi-cycle corner sequences.
module tb_sa_ws_controller;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] WA = 32'h0403_0201;  // {1,2,3,4}, element 0 in the low byte
  localparam logic [31:0] WB = 32'h0102_0304;  // {4,3,2,1}
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] J  = 32'hFFFF_FFFF;
  localparam logic [7:0]  N  = 8'd99;

  logic         clk, reset_n, start;
  logic [7:0]   num_vectors;
  logic         busy, done, w_valid, w_ready, a_valid, a_ready, sa_mode, out_valid;
  logic [31:0]  w_data, a_data, sa_w_in_vec, sa_a_in_vec;
  logic [127:0] sa_ps_out_vec, out_data;
  logic [7:0]   out_index;

  int checks = 0;
  int errors = 0;

  sa_ws_controller dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vectors(num_vectors),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .sa_mode(sa_mode),
    .sa_w_in_vec(sa_w_in_vec), .sa_a_in_vec(sa_a_in_vec), .sa_ps_out_vec(sa_ps_out_vec),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start; logic [7:0] num; logic wv; logic [31:0] wd; logic av; logic [31:0] ad;
    logic busy; logic done; logic wr; logic ar; logic mode;
    logic [31:0] win; logic [31:0] ain; logic ov; logic [7:0] idx;
  } vec_t;

  vec_t        tbl [25];
  logic [31:0] rows [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = L; num_vectors = 8'd0; w_valid = L; w_data = Z; a_valid = L; a_data = Z;
  endtask

  task automatic load_weights_continuous();
    w_valid = H;
    for (int j = 0; j < 4; j++) begin
      w_data = rows[j];
      tick();
    end
    w_valid = L;
    w_data  = Z;
  endtask

  initial begin
    int mode0_cnt, first_m0, last_m0, done_cnt, done_at, j, n, acc, ovc;
    logic ar_seen, ov_seen;
    logic [127:0] exp_data;

    rows[0] = WA; rows[1] = WB; rows[2] = WA; rows[3] = WB;
    //            start num   wv wd  av ad    busy done wr ar mode win ain ov idx
    tbl[0]  = '{H, 8'd4, L, Z,  L, Z,   H, L, H, L, H, Z,  Z,  L, 8'd0};
    tbl[1]  = '{L, N,    H, WA, H, WB,  H, L, H, L, H, Z,  Z,  L, 8'd0};
    tbl[2]  = '{L, N,    H, WB, H, WB,  H, L, H, L, H, Z,  Z,  L, 8'd0};
    tbl[3]  = '{L, N,    H, WA, L, Z,   H, L, H, L, H, Z,  Z,  L, 8'd0};
    tbl[4]  = '{L, N,    H, WB, L, Z,   H, L, L, L, L, WA, Z,  L, 8'd0};
    tbl[5]  = '{L, N,    H, J,  L, Z,   H, L, L, L, L, WB, Z,  L, 8'd0};
    tbl[6]  = '{L, N,    L, Z,  L, Z,   H, L, L, L, L, WA, Z,  L, 8'd0};
    tbl[7]  = '{L, N,    L, Z,  L, Z,   H, L, L, L, L, WB, Z,  L, 8'd0};
    tbl[8]  = '{L, N,    L, Z,  L, Z,   H, L, L, H, H, Z,  Z,  L, 8'd0};
    tbl[9]  = '{L, N,    L, Z,  H, WA,  H, L, L, H, H, Z,  WA, L, 8'd0};
    tbl[10] = '{H, 8'd1, L, Z,  H, WB,  H, L, L, H, H, Z,  WB, L, 8'd0};
    tbl[11] = '{L, N,    L, Z,  L, J,   H, L, L, H, H, Z,  Z,  L, 8'd0};
    tbl[12] = '{L, N,    L, Z,  H, WA,  H, L, L, H, H, Z,  WA, L, 8'd0};
    tbl[13] = '{L, N,    L, Z,  H, WB,  H, L, L, L, H, Z,  WB, L, 8'd0};
    tbl[14] = '{L, N,    L, Z,  H, WA,  H, L, L, L, H, Z,  Z,  L, 8'd0};
    tbl[15] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  L, 8'd0};
    tbl[16] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  L, 8'd0};
    tbl[17] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  L, 8'd0};
    tbl[18] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  H, 8'd0};
    tbl[19] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  H, 8'd1};
    tbl[20] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  L, 8'd1};
    tbl[21] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  H, 8'd2};
    tbl[22] = '{L, N,    L, Z,  L, Z,   H, L, L, L, H, Z,  Z,  H, 8'd3};
    tbl[23] = '{L, N,    L, Z,  L, Z,   H, H, L, L, H, Z,  Z,  L, 8'd3};
    tbl[24] = '{L, N,    L, Z,  L, Z,   L, L, L, L, H, Z,  Z,  L, 8'd3};

    // Reset values
    reset_n = L;
    idle_inputs();
    sa_ps_out_vec = '0;
    tick(); tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_wready", 128'(w_ready), 128'(0));
    check("rst_aready", 128'(a_ready), 128'(0));
    check("rst_mode", 128'(sa_mode), 128'(1));
    check("rst_win", 128'(sa_w_in_vec), 128'(0));
    check("rst_ain", 128'(sa_a_in_vec), 128'(0));
    check("rst_ov", 128'(out_valid), 128'(0));
    check("rst_odata", out_data, 128'(0));
    check("rst_oidx", 128'(out_index), 128'(0));
    reset_n = H;
    tick();

    // num_vectors = 0 with w_valid toggling: LOAD_W contiguous, then DONE, no streaming
    start = H; num_vectors = 8'd0;
    tick();
    start = L;
    j = 0; mode0_cnt = 0; first_m0 = -1; last_m0 = -1; done_cnt = 0; done_at = -1;
    ar_seen = L; ov_seen = L;
    for (int k = 0; k < 40; k++) begin
      w_valid = (k % 2 == 0) ? H : L;
      w_data  = (w_valid && j < 4) ? rows[j] : 32'hDEAD_BEEF;
      tick();
      if (w_valid && j < 4) j++;
      if (!sa_mode) begin
        mode0_cnt++;
        if (first_m0 < 0) first_m0 = k;
        last_m0 = k;
        if (mode0_cnt <= 4) check($sformatf("z_row%0d", mode0_cnt - 1), 128'(sa_w_in_vec), 128'(rows[mode0_cnt - 1]));
      end
      if (done) begin done_cnt++; done_at = k; end
      if (a_ready) ar_seen = H;
      if (out_valid) ov_seen = H;
    end
    idle_inputs();
    check("z_load_cycles", 128'(mode0_cnt), 128'(4));
    check("z_load_contig", 128'(last_m0 - first_m0), 128'(3));
    check("z_done_cnt", 128'(done_cnt), 128'(1));
    check("z_done_after_load", 128'(done_at), 128'(last_m0 + 1));
    check("z_aready_never", 128'(ar_seen), 128'(0));
    check("z_ov_never", 128'(ov_seen), 128'(0));
    check("z_idle_busy", 128'(busy), 128'(0));

    // Reset mid-STREAM after two accepted vectors
    start = H; num_vectors = 8'd4;
    tick();
    start = L;
    load_weights_continuous();
    n = 0;
    while (!a_ready && n < 20) begin tick(); n++; end
    check("c_stream_reached", 128'(a_ready), 128'(1));
    a_valid = H; a_data = WA; tick();
    a_data = WB; tick();
    a_valid = L; a_data = Z;
    #2 reset_n = L;
    #1;
    check("c_busy", 128'(busy), 128'(0));
    check("c_ov", 128'(out_valid), 128'(0));
    check("c_mode", 128'(sa_mode), 128'(1));
    check("c_done", 128'(done), 128'(0));
    check("c_aready", 128'(a_ready), 128'(0));
    check("c_ain", 128'(sa_a_in_vec), 128'(0));
    tick(); tick();
    reset_n = H;
    tick();

    // Fresh tile, cycle by cycle against the vector table
    exp_data = '0;
    for (int i = 0; i < 25; i++) begin
      start = tbl[i].start; num_vectors = tbl[i].num;
      w_valid = tbl[i].wv; w_data = tbl[i].wd;
      a_valid = tbl[i].av; a_data = tbl[i].ad;
      sa_ps_out_vec = {4{32'hA500_0000 + 32'(i)}};
      tick();
      if (tbl[i].ov) exp_data = {4{32'hA500_0000 + 32'(i)}};
      check($sformatf("t%0d_busy", i), 128'(busy), 128'(tbl[i].busy));
      check($sformatf("t%0d_done", i), 128'(done), 128'(tbl[i].done));
      check($sformatf("t%0d_wready", i), 128'(w_ready), 128'(tbl[i].wr));
      check($sformatf("t%0d_aready", i), 128'(a_ready), 128'(tbl[i].ar));
      check($sformatf("t%0d_mode", i), 128'(sa_mode), 128'(tbl[i].mode));
      check($sformatf("t%0d_win", i), 128'(sa_w_in_vec), 128'(tbl[i].win));
      check($sformatf("t%0d_ain", i), 128'(sa_a_in_vec), 128'(tbl[i].ain));
      check($sformatf("t%0d_ov", i), 128'(out_valid), 128'(tbl[i].ov));
      check($sformatf("t%0d_oidx", i), 128'(out_index), 128'(tbl[i].idx));
      check($sformatf("t%0d_odata", i), out_data, exp_data);
    end
    idle_inputs();
    sa_ps_out_vec = '0;
    tick();

    // Maximum count: 255 vectors must not wrap the index counter
    start = H; num_vectors = 8'd255;
    tick();
    start = L;
    load_weights_continuous();
    a_valid = H; acc = 0; ovc = 0; done_cnt = 0;
    for (int k = 0; k < 330; k++) begin
      a_data = 32'(k);
      if (a_ready) acc++;
      tick();
      if (out_valid) begin
        check($sformatf("m_idx%0d", ovc), 128'(out_index), 128'(ovc));
        ovc++;
      end
      if (done) done_cnt++;
    end
    idle_inputs();
    check("m_accepted", 128'(acc), 128'(255));
    check("m_rows_out", 128'(ovc), 128'(255));
    check("m_done_cnt", 128'(done_cnt), 128'(1));
    check("m_idle_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
